// File: rtl/memory_lane_unit.sv
// ---------------------------------------------------------------------------
// memory_lane_unit
//   Pipelined data-memory access unit for the CPU memory stage. Memory is
//   split into LANES byte-wide banks (byte B lives in bank B mod LANES, row
//   B / LANES). Accesses are 2^size bytes, big-endian, at any alignment; a
//   misaligned access that runs past the last bank wraps to row+1 in the low
//   banks. Requests use valid/ready; every request yields one registered
//   response one cycle after accept, held under backpressure.
//
//   Optional build macro: MEMIO_SIGN_EXT_EN -- when defined, loads with
//   i_req_signed=1 sign-extend from bit 8N-1; otherwise all loads are
//   zero-extended and i_req_signed is ignored.
//
// Ports
//   i_clock, i_reset        clock, synchronous active-high reset
//   i_req_valid/o_req_ready request handshake
//   i_req_store             1 = store, 0 = load
//   i_req_size              log2 of access size in bytes (clamped to LANES)
//   i_req_signed            sign-extend load result (macro dependent)
//   i_req_addr              byte address
//   i_req_wdata             store data, right-justified
//   o_resp_valid/i_resp_ready response handshake
//   o_resp_store            response acknowledges a store
//   o_resp_rdata            load result, zero for store responses
// ---------------------------------------------------------------------------

// One byte-wide bank with a synchronous, enable-gated read port. The read
// register only moves on a read enable, which is what lets a stalled
// response keep its data without a skid buffer.
module memory_lane_bank #(
   parameter int ROW_W = 16
) (
   input  logic             i_clock,
   input  logic             i_we,
   input  logic             i_re,
   input  logic [ROW_W-1:0] i_row,
   input  logic [7:0]       i_wdata,
   output logic [7:0]       o_rdata
);
   logic [7:0] r_mem [0:(1<<ROW_W)-1];
   logic [7:0] r_rdata;

   always_ff @(posedge i_clock) begin
      if (i_we) r_mem[i_row] <= i_wdata;
      if (i_re) r_rdata <= r_mem[i_row];
   end

   assign o_rdata = r_rdata;
endmodule

module memory_lane_unit #(
   parameter int LANES  = 4,
   parameter int ADDR_W = 18,
   parameter int DW     = 8*LANES
) (
   input  logic                                i_clock,
   input  logic                                i_reset,
   input  logic                                i_req_valid,
   output logic                                o_req_ready,
   input  logic                                i_req_store,
   input  logic [$clog2($clog2(LANES)+1)-1:0]  i_req_size,
   input  logic                                i_req_signed,
   input  logic [ADDR_W-1:0]                   i_req_addr,
   input  logic [DW-1:0]                       i_req_wdata,
   output logic                                o_resp_valid,
   input  logic                                i_resp_ready,
   output logic                                o_resp_store,
   output logic [DW-1:0]                       o_resp_rdata
);
   localparam int LG    = $clog2(LANES);
   localparam int SW    = $clog2(LG+1);
   localparam int ROW_W = ADDR_W - LG;

   typedef enum logic {S_IDLE, S_VALID} state_t;

   // Response-stage bookkeeping captured at accept.
   typedef struct packed {
      logic          store;
      logic [LG-1:0] lo;    // byte offset of the first byte within a row
      logic [LG:0]   nb;    // access size in bytes
`ifdef MEMIO_SIGN_EXT_EN
      logic          sgn;
`endif
   } meta_t;

   state_t r_state, w_next;
   meta_t  r_meta, w_meta;

   logic                      w_resp_valid;
   logic                      w_accept;
   logic [LG-1:0]             w_lo;
   logic [ROW_W-1:0]          w_row;
   logic [LG:0]               w_nb;
   logic [LANES-1:0][7:0]     w_wbytes;
   logic [LANES-1:0][7:0]     w_bank_rd;
   logic [LANES-1:0][7:0]     w_asm;

   // -------------------------------------------------------------------------
   // Request decode
   // -------------------------------------------------------------------------
   assign w_resp_valid = (r_state == S_VALID);
   assign o_req_ready  = ~w_resp_valid | i_resp_ready;
   assign w_accept     = i_req_valid & o_req_ready & ~i_reset;

   assign w_lo     = i_req_addr[LG-1:0];
   assign w_row    = i_req_addr[ADDR_W-1:LG];
   assign w_wbytes = i_req_wdata;

   // Oversized requests collapse to a full-width access.
   always_comb begin
      if (i_req_size > SW'(LG)) w_nb = (LG+1)'(LANES);
      else                      w_nb = (LG+1)'(1) << i_req_size;
   end

   // -------------------------------------------------------------------------
   // Per-bank address/data steering
   //   k = position of this bank's byte within the access (0 = address A).
   //   Banks below the start offset hold bytes that spilled into the next row.
   // -------------------------------------------------------------------------
   for (genvar b = 0; b < LANES; b++) begin : g_lane
      logic [LG-1:0]    w_k;
      logic             w_in;
      logic [LG:0]      w_sel;
      logic [ROW_W-1:0] w_brow;

      assign w_k    = LG'(b) - w_lo;
      assign w_in   = {1'b0, w_k} < w_nb;
      // Big-endian: byte k of the access comes from wdata byte N-1-k.
      assign w_sel  = w_nb - (LG+1)'(1) - {1'b0, w_k};
      assign w_brow = w_row + ROW_W'(LG'(b) < w_lo);

      memory_lane_bank #(.ROW_W(ROW_W)) u_bank (
         .i_clock (i_clock),
         .i_we    (w_accept & i_req_store & w_in),
         .i_re    (w_accept & ~i_req_store),
         .i_row   (w_brow),
         .i_wdata (w_wbytes[w_sel[LG-1:0]]),
         .o_rdata (w_bank_rd[b])
      );
   end

   // -------------------------------------------------------------------------
   // Response-stage FSM
   // -------------------------------------------------------------------------
   always_ff @(posedge i_clock) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next = S_VALID;
         S_VALID: if (i_resp_ready && !w_accept) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_meta       = '0;
      w_meta.store = i_req_store;
      w_meta.lo    = w_lo;
      w_meta.nb    = w_nb;
`ifdef MEMIO_SIGN_EXT_EN
      w_meta.sgn   = i_req_signed;
`endif
   end

   always_ff @(posedge i_clock) begin
      if (i_reset)       r_meta <= '0;
      else if (w_accept) r_meta <= w_meta;
   end

`ifndef MEMIO_SIGN_EXT_EN
   logic w_unused_signed;
   assign w_unused_signed = i_req_signed;
`endif

   // -------------------------------------------------------------------------
   // Load assembly: rotate bank outputs so access byte k lands in result
   // byte N-1-k, then extend above 8N.
   // -------------------------------------------------------------------------
   always_comb begin
      logic [LG-1:0] idx;
      logic          fill;
      w_asm = '0;
      fill  = 1'b0;
      for (int k = 0; k < LANES; k++) begin
         idx = r_meta.lo + LG'(k);
         if (k < int'(r_meta.nb))
            w_asm[LG'(int'(r_meta.nb) - 1 - k)] = w_bank_rd[idx];
      end
`ifdef MEMIO_SIGN_EXT_EN
      fill = r_meta.sgn & w_asm[LG'(int'(r_meta.nb) - 1)][7];
`endif
      // Full-width accesses have no bytes above 8N, so they are never extended.
      for (int j = 0; j < LANES; j++) begin
         if (j >= int'(r_meta.nb)) w_asm[j] = {8{fill}};
      end
   end

   assign o_resp_valid = w_resp_valid;
   assign o_resp_store = w_resp_valid & r_meta.store;
   assign o_resp_rdata = (w_resp_valid & ~r_meta.store) ? w_asm : '0;
endmodule

// File: tb/tb_memory_lane_unit.sv
module tb_memory_lane_unit;
   localparam int LANES  = 4;
   localparam int ADDR_W = 18;
   localparam int DW     = 32;

   logic              i_clock = 1'b0;
   logic              i_reset;
   logic              i_req_valid;
   logic              o_req_ready;
   logic              i_req_store;
   logic [1:0]        i_req_size;
   logic              i_req_signed;
   logic [ADDR_W-1:0] i_req_addr;
   logic [DW-1:0]     i_req_wdata;
   logic              o_resp_valid;
   logic              i_resp_ready;
   logic              o_resp_store;
   logic [DW-1:0]     o_resp_rdata;

   always #5 i_clock = ~i_clock;

   memory_lane_unit #(.LANES(LANES), .ADDR_W(ADDR_W)) dut (
      .i_clock      (i_clock),
      .i_reset      (i_reset),
      .i_req_valid  (i_req_valid),
      .o_req_ready  (o_req_ready),
      .i_req_store  (i_req_store),
      .i_req_size   (i_req_size),
      .i_req_signed (i_req_signed),
      .i_req_addr   (i_req_addr),
      .i_req_wdata  (i_req_wdata),
      .o_resp_valid (o_resp_valid),
      .i_resp_ready (i_resp_ready),
      .o_resp_store (o_resp_store),
      .o_resp_rdata (o_resp_rdata)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit        st;
      bit [31:0] d;
   } rsp_t;

   rsp_t     exp_q[$];
   bit [7:0] mem [int];   // flat byte-addressed reference memory

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic int nbytes(input bit [1:0] sz);
      return (sz > 2'd2) ? 4 : (1 << sz);
   endfunction

   function automatic void mdl_store(input bit [17:0] a, input bit [1:0] sz, input bit [31:0] wd);
      int n = nbytes(sz);
      bit [17:0] b;
      for (int k = 0; k < n; k++) begin
         b = a + 18'(k);
         mem[int'(b)] = 8'(wd >> (8*(n-1-k)));
      end
   endfunction

   function automatic bit [31:0] mdl_load(input bit [17:0] a, input bit [1:0] sz, input bit sg);
      int n = nbytes(sz);
      bit [31:0] v = 32'h0;
      bit [17:0] b;
      bit        sext;
      sext = sg;
`ifndef MEMIO_SIGN_EXT_EN
      sext = 1'b0;
`endif
      for (int k = 0; k < n; k++) begin
         b = a + 18'(k);
         v = (v << 8) | 32'(mem.exists(int'(b)) ? mem[int'(b)] : 8'h00);
      end
      if (sext && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8*n)) - 32'h1);
      return v;
   endfunction

   // One clock of activity: drive, check the visible response, update model.
   task automatic step(input bit v, input bit st, input bit [1:0] sz, input bit sg,
                       input bit [17:0] a, input bit [31:0] wd, input bit rr, output bit acc);
      bit   rdy;
      rsp_t r;
      i_req_valid  = v;
      i_req_store  = st;
      i_req_size   = sz;
      i_req_signed = sg;
      i_req_addr   = a;
      i_req_wdata  = wd;
      i_resp_ready = rr;
      #1;
      rdy = (exp_q.size() == 0) || rr;
      chk("req_ready", 32'(o_req_ready), 32'(rdy));
      chk("resp_valid", 32'(o_resp_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
         chk("resp_store", 32'(o_resp_store), 32'(exp_q[0].st));
         chk("resp_rdata", o_resp_rdata, exp_q[0].d);
         if (rr) void'(exp_q.pop_front());
      end
      acc = v && rdy;
      if (acc) begin
         r.st = st;
         if (st) begin
            mdl_store(a, sz, wd);
            r.d = 32'h0;
         end else begin
            r.d = mdl_load(a, sz, sg);
         end
         exp_q.push_back(r);
      end
      @(posedge i_clock);
      #1;
   endtask

   task automatic issue(input bit st, input bit [1:0] sz, input bit sg, input bit [17:0] a, input bit [31:0] wd);
      bit acc;
      int n = 0;
      do begin
         step(1'b1, st, sz, sg, a, wd, 1'b1, acc);
         n++;
      end while (!acc && n < 20);
      if (!acc) chk("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic idle();
      bit acc;
      step(1'b0, 1'b0, 2'd0, 1'b0, 18'h0, 32'h0, 1'b1, acc);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit        acc;
      bit [17:0] la [3];
      int        idx;
      bit        pend, pst, psg, rr;
      bit [1:0]  psz;
      bit [17:0] pa;
      bit [31:0] pwd;

      i_reset = 1'b1; i_req_valid = 1'b0; i_req_store = 1'b0; i_req_size = 2'd0;
      i_req_signed = 1'b0; i_req_addr = '0; i_req_wdata = '0; i_resp_ready = 1'b0;
      repeat (2) @(posedge i_clock);
      #1;
      i_reset = 1'b0;
      #1;
      chk("rst_resp_valid", 32'(o_resp_valid), 32'd0);
      chk("rst_resp_store", 32'(o_resp_store), 32'd0);
      chk("rst_resp_rdata", o_resp_rdata, 32'd0);
      chk("rst_req_ready", 32'(o_req_ready), 32'd1);
      @(posedge i_clock);
      #1;

      // aligned word
      issue(1'b1, 2'd2, 1'b0, 18'h00010, 32'hDEADBEEF);
      issue(1'b0, 2'd2, 1'b0, 18'h00010, 32'h0);
      idle();

      // row-crossing misaligned word, read back bytewise
      issue(1'b1, 2'd2, 1'b0, 18'h00007, 32'h11223344);
      for (int i = 0; i < 4; i++) issue(1'b0, 2'd0, 1'b0, 18'h00007 + 18'(i), 32'h0);
      issue(1'b0, 2'd2, 1'b0, 18'h00007, 32'h0);
      idle();

      // half / byte with sign
      issue(1'b1, 2'd1, 1'b0, 18'h00020, 32'h000080FF);
      issue(1'b0, 2'd1, 1'b1, 18'h00020, 32'h0);
      issue(1'b0, 2'd1, 1'b0, 18'h00020, 32'h0);
      issue(1'b0, 2'd0, 1'b0, 18'h00021, 32'h0);
      issue(1'b0, 2'd0, 1'b1, 18'h00021, 32'h0);
      issue(1'b0, 2'd0, 1'b1, 18'h00020, 32'h0);
      idle();

      // backpressure: three loads, consumer stalled for 4 cycles
      la[0] = 18'h00010; la[1] = 18'h00007; la[2] = 18'h00010;
      idx = 0;
      for (int c = 0; c < 30 && idx < 3; c++) begin
         step(1'b1, 1'b0, 2'd2, 1'b0, la[idx], 32'h0, c >= 4, acc);
         if (acc) idx++;
      end
      if (idx != 3) chk("bp_timeout", 32'(idx), 32'd3);
      idle();
      idle();

      // address wrap at top of memory
      issue(1'b1, 2'd2, 1'b0, 18'h3FFFE, 32'hA1B2C3D4);
      issue(1'b0, 2'd0, 1'b0, 18'h00000, 32'h0);
      issue(1'b0, 2'd0, 1'b0, 18'h00001, 32'h0);
      issue(1'b0, 2'd0, 1'b0, 18'h3FFFE, 32'h0);
      issue(1'b0, 2'd2, 1'b0, 18'h3FFFE, 32'h0);
      idle();

      // reset mid-flight with a store presented during reset
      issue(1'b0, 2'd2, 1'b0, 18'h00010, 32'h0);
      i_reset = 1'b1; i_req_valid = 1'b1; i_req_store = 1'b1; i_req_size = 2'd2;
      i_req_addr = 18'h00010; i_req_wdata = 32'h55AA55AA; i_resp_ready = 1'b1;
      @(posedge i_clock);
      #1;
      exp_q.delete();
      i_reset = 1'b0; i_req_valid = 1'b0;
      #1;
      chk("midrst_resp_valid", 32'(o_resp_valid), 32'd0);
      chk("midrst_resp_rdata", o_resp_rdata, 32'd0);
      @(posedge i_clock);
      #1;
      issue(1'b0, 2'd2, 1'b0, 18'h00010, 32'h0);
      idle();

      // randomized traffic inside an initialised window
      for (int i = 0; i < 16; i++) issue(1'b1, 2'd2, 1'b0, 18'(i*4), $urandom);
      pend = 1'b0; pst = 1'b0; psg = 1'b0; psz = 2'd0; pa = '0; pwd = '0;
      for (int c = 0; c < 400; c++) begin
         if (!pend) begin
            pend = ($urandom_range(0, 3) != 0);
            pst  = 1'($urandom_range(0, 1));
            psz  = 2'($urandom_range(0, 3));
            psg  = 1'($urandom_range(0, 1));
            pa   = 18'($urandom_range(0, 60));
            pwd  = $urandom;
         end
         rr = ($urandom_range(0, 3) != 0);
         step(pend, pst, psz, psg, pa, pwd, rr, acc);
         if (acc) pend = 1'b0;
      end
      repeat (3) idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
